round_control: RTL and testbench

- Match/round sequencer that sits directly downstream of death_control.
- Consumes death_control's kill, clash and board-position results and turns them into the round flow: play, freeze on a kill, respawn, game over.
- Drives pos_reset back to the player-position blocks.
- Drives freeze/advance flags to the player-motion and renderer stages.
- Keeps per-player kill scores.

---
 rtl/nidhogg_pkg.sv | 33 +++
 rtl/frame_timer.sv | 46 ++++
 rtl/round_control.sv | 236 +++++++++++++++++++++++
 tb/tb_round_control.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/nidhogg_pkg.sv
// Shared definitions for the match/round control slice.
// Holds the round FSM state codes, winner codes, score/board widths and a
// saturating score increment used by round_control.
package nidhogg_pkg;

    localparam int SCORE_W = 4;
    localparam int BOARD_W = 3;

    // Round FSM states; the codes are exported on the state port for the HUD.
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PLAY      = 3'd1,
        FREEZE    = 3'd2,
        RESPAWN   = 3'd3,
        GAME_OVER = 3'd4
    } state_t;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_L    = 2'b01;
    localparam logic [1:0] WIN_R    = 2'b10;

    // Kill score +1, sticking at the maximum instead of wrapping to zero.
    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] value);
        logic [SCORE_W-1:0] result;
        if (value == {SCORE_W{1'b1}}) begin
            result = value;
        end else begin
            result = value + {{(SCORE_W-1){1'b0}}, 1'b1};
        end
        return result;
    endfunction

endpackage

// File: rtl/frame_timer.sv
// Frame-tick counter shared by the FREEZE and RESPAWN windows.
// Ports:
//   clk, reset  - system clock, synchronous active-high reset
//   clear       - force the count back to 0 (wins over tick)
//   tick        - count one frame (already gated by the caller)
//   limit       - window length in ticks (1..255); the count saturates here
//   expire      - window complete: count already at limit, or this tick
//                 takes it there
module frame_timer (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       tick,
    input  logic [7:0] limit,
    output logic       expire
);

    logic [7:0] count_r;

    // Tick counter with clear priority, saturating at the limit.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= 8'd0;
        end else if (clear) begin
            count_r <= 8'd0;
        end else if (tick && (count_r != limit)) begin
            count_r <= count_r + 8'd1;
        end else begin
            count_r <= count_r;
        end
    end

    // Terminal count, including the tick that completes the window so the
    // caller can leave on that very edge.
    always_comb begin
        expire = 1'b0;
        if (count_r == limit) begin
            expire = 1'b1;
        end else if (tick && (count_r == (limit - 8'd1))) begin
            expire = 1'b1;
        end else begin
            expire = 1'b0;
        end
    end

endmodule

// File: rtl/round_control.sv
// Match/round sequencer downstream of death_control.
// Turns kill, clash and board-position results into the round flow
// (IDLE -> PLAY -> FREEZE -> RESPAWN -> PLAY ..., GAME_OVER on a board win)
// and keeps per-player kill scores.
// Ports:
//   clk, reset            - system clock, synchronous active-high reset
//   frame_tick            - one-cycle pulse per video frame
//   start                 - start/restart request (level or pulse)
//   dead_L, dead_R        - player killed levels from death_control
//   collision             - sword clash level
//   board_controller      - signed board index (-4..+3)
//   pos_reset             - one-cycle pulse: re-place both players
//   freeze                - motion inputs ignored
//   advance_L, advance_R  - right-of-way flags
//   clash                 - one-cycle pulse on a collision rise in PLAY
//   score_L, score_R      - saturating kill counts
//   winner                - 00 none, 01 left, 10 right
//   state                 - current FSM state code
// All outputs are registered.
module round_control
    import nidhogg_pkg::*;
#(
    parameter int FREEZE_FRAMES  = 30,
    parameter int RESPAWN_FRAMES = 60,
    parameter int WIN_STEPS      = 3
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_tick,
    input  logic                start,
    input  logic                dead_L,
    input  logic                dead_R,
    input  logic                collision,
    input  logic [BOARD_W-1:0]  board_controller,
    output logic                pos_reset,
    output logic                freeze,
    output logic                advance_L,
    output logic                advance_R,
    output logic                clash,
    output logic [SCORE_W-1:0]  score_L,
    output logic [SCORE_W-1:0]  score_R,
    output logic [1:0]          winner,
    output logic [2:0]          state
);

    localparam logic [7:0] FREEZE_LIMIT  = 8'(FREEZE_FRAMES);
    localparam logic [7:0] RESPAWN_LIMIT = 8'(RESPAWN_FRAMES);
    // One extra bit so +WIN_STEPS and -WIN_STEPS are both representable.
    localparam logic signed [BOARD_W:0] WIN_POS = (BOARD_W+1)'(WIN_STEPS);
    localparam logic signed [BOARD_W:0] WIN_NEG = -WIN_POS;

    state_t               state_r, next_state_s;
    logic                 dead_l_prev_r, dead_r_prev_r, collision_prev_r;
    logic                 pos_reset_r, freeze_r, advance_l_r, advance_r_r, clash_r;
    logic [SCORE_W-1:0]   score_l_r, score_r_r;
    logic [1:0]           winner_r;

    logic                 pos_reset_s, freeze_s, advance_l_s, advance_r_s, clash_s;
    logic [SCORE_W-1:0]   score_l_s, score_r_s;
    logic [1:0]           winner_s;
    logic                 rise_dead_l_s, rise_dead_r_s, rise_collision_s;
    logic                 board_win_l_s, board_win_r_s;
    logic signed [BOARD_W:0] board_ext_s;
    logic                 timer_clear_s, timer_tick_s, timer_expire_s;
    logic [7:0]           timer_limit_s;

    frame_timer u_frame_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear_s),
        .tick   (timer_tick_s),
        .limit  (timer_limit_s),
        .expire (timer_expire_s)
    );

    // Rise detection on the death_control levels and the board win test.
    always_comb begin
        rise_dead_l_s    = dead_L    & ~dead_l_prev_r;
        rise_dead_r_s    = dead_R    & ~dead_r_prev_r;
        rise_collision_s = collision & ~collision_prev_r;
        board_ext_s      = signed'({board_controller[BOARD_W-1], board_controller});
        board_win_l_s    = (board_ext_s >= WIN_POS);
        board_win_r_s    = (board_ext_s <= WIN_NEG);
    end

    // Timer control: restart on every state change, count only in the windows.
    always_comb begin
        timer_clear_s = (next_state_s != state_r);
        timer_tick_s  = frame_tick && ((state_r == FREEZE) || (state_r == RESPAWN));
        if (state_r == FREEZE) begin
            timer_limit_s = FREEZE_LIMIT;
        end else begin
            timer_limit_s = RESPAWN_LIMIT;
        end
    end

    // Next-state and next-output logic of the round FSM.
    always_comb begin
        next_state_s = state_r;
        pos_reset_s  = 1'b0;
        clash_s      = 1'b0;
        advance_l_s  = advance_l_r;
        advance_r_s  = advance_r_r;
        score_l_s    = score_l_r;
        score_r_s    = score_r_r;
        winner_s     = winner_r;
        case (state_r)
            IDLE: begin
                if (start) begin
                    next_state_s = PLAY;
                    pos_reset_s  = 1'b1;
                end else begin
                    next_state_s = IDLE;
                end
            end
            PLAY: begin
                // A board win masks any kill arriving in the same cycle.
                if (board_win_l_s) begin
                    next_state_s = GAME_OVER;
                    winner_s     = WIN_L;
                end else if (board_win_r_s) begin
                    next_state_s = GAME_OVER;
                    winner_s     = WIN_R;
                end else if (rise_dead_l_s && rise_dead_r_s) begin
                    next_state_s = FREEZE;
                    advance_l_s  = 1'b0;
                    advance_r_s  = 1'b0;
                end else if (rise_dead_r_s) begin
                    next_state_s = FREEZE;
                    score_l_s    = sat_inc(score_l_r);
                    advance_l_s  = 1'b1;
                    advance_r_s  = 1'b0;
                end else if (rise_dead_l_s) begin
                    next_state_s = FREEZE;
                    score_r_s    = sat_inc(score_r_r);
                    advance_l_s  = 1'b0;
                    advance_r_s  = 1'b1;
                end else if (rise_collision_s) begin
                    clash_s = 1'b1;
                end else begin
                    next_state_s = PLAY;
                end
            end
            FREEZE: begin
                if (timer_expire_s) begin
                    next_state_s = RESPAWN;
                    pos_reset_s  = 1'b1;
                end else begin
                    next_state_s = FREEZE;
                end
            end
            RESPAWN: begin
                // The timer holds at its limit while a player is still down.
                if (board_win_l_s) begin
                    next_state_s = GAME_OVER;
                    winner_s     = WIN_L;
                end else if (board_win_r_s) begin
                    next_state_s = GAME_OVER;
                    winner_s     = WIN_R;
                end else if (timer_expire_s && !dead_L && !dead_R) begin
                    next_state_s = PLAY;
                end else begin
                    next_state_s = RESPAWN;
                end
            end
            GAME_OVER: begin
                if (start) begin
                    next_state_s = PLAY;
                    pos_reset_s  = 1'b1;
                    score_l_s    = {SCORE_W{1'b0}};
                    score_r_s    = {SCORE_W{1'b0}};
                    advance_l_s  = 1'b0;
                    advance_r_s  = 1'b0;
                    winner_s     = WIN_NONE;
                end else begin
                    next_state_s = GAME_OVER;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
        // freeze is registered alongside the state so both change together.
        freeze_s = (next_state_s == IDLE) || (next_state_s == FREEZE) ||
                   (next_state_s == GAME_OVER);
    end

    // State register and edge-detector history.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r          <= IDLE;
            dead_l_prev_r    <= 1'b0;
            dead_r_prev_r    <= 1'b0;
            collision_prev_r <= 1'b0;
        end else begin
            state_r          <= next_state_s;
            dead_l_prev_r    <= dead_L;
            dead_r_prev_r    <= dead_R;
            collision_prev_r <= collision;
        end
    end

    // Registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_reset_r <= 1'b0;
            freeze_r    <= 1'b1;
            advance_l_r <= 1'b0;
            advance_r_r <= 1'b0;
            clash_r     <= 1'b0;
            score_l_r   <= {SCORE_W{1'b0}};
            score_r_r   <= {SCORE_W{1'b0}};
            winner_r    <= WIN_NONE;
        end else begin
            pos_reset_r <= pos_reset_s;
            freeze_r    <= freeze_s;
            advance_l_r <= advance_l_s;
            advance_r_r <= advance_r_s;
            clash_r     <= clash_s;
            score_l_r   <= score_l_s;
            score_r_r   <= score_r_s;
            winner_r    <= winner_s;
        end
    end

    assign pos_reset = pos_reset_r;
    assign freeze    = freeze_r;
    assign advance_L = advance_l_r;
    assign advance_R = advance_r_r;
    assign clash     = clash_r;
    assign score_L   = score_l_r;
    assign score_R   = score_r_r;
    assign winner    = winner_r;
    assign state     = state_r;

endmodule

// File: tb/tb_round_control.sv
// Scoreboard bench for round_control. The stimulus process queues the
// expected output snapshot for every observable event; a monitor pops one
// snapshot whenever the DUT changes state or pulses pos_reset/clash.
module tb_round_control;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PLAY = 3'd1;
    localparam logic [2:0] S_FRZ  = 3'd2;
    localparam logic [2:0] S_RSP  = 3'd3;
    localparam logic [2:0] S_GO   = 3'd4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       frame_tick = 1'b0;
    logic       start = 1'b0;
    logic       dead_L = 1'b0;
    logic       dead_R = 1'b0;
    logic       collision = 1'b0;
    logic [2:0] board_controller = 3'b000;
    logic       pos_reset, freeze, advance_L, advance_R, clash;
    logic [3:0] score_L, score_R;
    logic [1:0] winner;
    logic [2:0] state;

    typedef struct packed {
        logic [2:0] st;
        logic       pr;
        logic       fr;
        logic       al;
        logic       ar;
        logic       cl;
        logic [3:0] sl;
        logic [3:0] sr;
        logic [1:0] win;
    } snap_t;

    snap_t exp_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    int    evt_n   = 0;

    round_control #(.FREEZE_FRAMES(30), .RESPAWN_FRAMES(60), .WIN_STEPS(3)) dut (
        .clk              (clk),
        .reset            (reset),
        .frame_tick       (frame_tick),
        .start            (start),
        .dead_L           (dead_L),
        .dead_R           (dead_R),
        .collision        (collision),
        .board_controller (board_controller),
        .pos_reset        (pos_reset),
        .freeze           (freeze),
        .advance_L        (advance_L),
        .advance_R        (advance_R),
        .clash            (clash),
        .score_L          (score_L),
        .score_R          (score_R),
        .winner           (winner),
        .state            (state)
    );

    always #5 clk = ~clk;

    function automatic snap_t mk(input logic [2:0] st, input logic pr, input logic fr,
                                 input logic al, input logic ar, input logic cl,
                                 input logic [3:0] sl, input logic [3:0] sr,
                                 input logic [1:0] win);
        snap_t s;
        s.st = st; s.pr = pr; s.fr = fr; s.al = al; s.ar = ar; s.cl = cl;
        s.sl = sl; s.sr = sr; s.win = win;
        return s;
    endfunction

    function automatic snap_t act();
        return mk(state, pos_reset, freeze, advance_L, advance_R, clash,
                  score_L, score_R, winner);
    endfunction

    task automatic compare(input string name, input snap_t a, input snap_t e);
        n_tests++;
        if (a !== e) begin
            n_fail++;
            $display("FAIL %s: got st=%0d pr=%b fr=%b al=%b ar=%b cl=%b sL=%0d sR=%0d win=%b, expected st=%0d pr=%b fr=%b al=%b ar=%b cl=%b sL=%0d sR=%0d win=%b",
                     name, a.st, a.pr, a.fr, a.al, a.ar, a.cl, a.sl, a.sr, a.win,
                     e.st, e.pr, e.fr, e.al, e.ar, e.cl, e.sl, e.sr, e.win);
        end
    endtask

    // Monitor: an event is a state change or a pos_reset/clash pulse.
    initial begin
        logic [2:0] last_state;
        snap_t      e;
        string      nm;
        last_state = S_IDLE;
        forever begin
            @(negedge clk);
            if (!reset && ((state != last_state) || pos_reset || clash)) begin
                evt_n++;
                nm = $sformatf("event%0d", evt_n);
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL %s: unexpected event st=%0d pr=%b cl=%b, expected no event",
                             nm, state, pos_reset, clash);
                end else begin
                    e = exp_q.pop_front();
                    compare(nm, act(), e);
                end
            end
            last_state = state;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        repeat (40000) @(posedge clk);
        n_fail++;
        $display("FAIL watchdog: got timeout, expected end of stimulus");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One frame tick every three clocks.
    task automatic ticks(input int n);
        repeat (n) begin
            frame_tick = 1'b1;
            cyc(1);
            frame_tick = 1'b0;
            cyc(2);
        end
    endtask

    initial begin
        logic [3:0] s;
        // Reset state
        cyc(3);
        @(negedge clk);
        compare("reset_values", act(), mk(S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00));
        reset = 1'b0;
        cyc(2);
        ticks(2);                       // frame ticks in IDLE do nothing

        // 1: start -> PLAY with a single pos_reset pulse
        exp_q.push_back(mk(S_PLAY, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00));
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        start = 1'b1;                   // ignored in PLAY
        cyc(1);
        start = 1'b0;
        cyc(2);

        // 2: dead_L held for 100 frames
        exp_q.push_back(mk(S_FRZ, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 2'b00));
        dead_L = 1'b1;
        cyc(1);
        exp_q.push_back(mk(S_RSP, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 2'b00));
        ticks(30);
        ticks(70);
        exp_q.push_back(mk(S_PLAY, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 4'd1, 2'b00));
        dead_L = 1'b0;
        cyc(3);

        // 3: double kill, then the exact 60-tick respawn boundary
        exp_q.push_back(mk(S_FRZ, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 2'b00));
        dead_L = 1'b1;
        dead_R = 1'b1;
        cyc(1);
        dead_L = 1'b0;
        dead_R = 1'b0;
        exp_q.push_back(mk(S_RSP, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 2'b00));
        ticks(30);
        ticks(59);
        cyc(2);
        exp_q.push_back(mk(S_PLAY, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 2'b00));
        ticks(1);
        cyc(2);

        // 4: board +2 / -2 are no win; +3 beats a simultaneous kill; -3; restart
        board_controller = 3'b010;
        cyc(3);
        board_controller = 3'b110;
        cyc(3);
        exp_q.push_back(mk(S_GO, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd1, 2'b01));
        board_controller = 3'b011;
        dead_R = 1'b1;
        cyc(1);
        dead_R = 1'b0;
        board_controller = 3'b000;
        cyc(3);
        exp_q.push_back(mk(S_PLAY, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00));
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);
        exp_q.push_back(mk(S_GO, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b10));
        board_controller = 3'b101;
        cyc(1);
        board_controller = 3'b000;
        cyc(3);
        exp_q.push_back(mk(S_PLAY, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00));
        start = 1'b1;
        cyc(1);
        start = 1'b0;
        cyc(3);

        // 5: 16 left-player kills; score_L sticks at 15
        for (int k = 1; k <= 16; k++) begin
            s = (k > 15) ? 4'd15 : 4'(k);
            exp_q.push_back(mk(S_FRZ, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, s, 4'd0, 2'b00));
            dead_R = 1'b1;
            cyc(1);
            dead_R = 1'b0;
            exp_q.push_back(mk(S_RSP, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, s, 4'd0, 2'b00));
            ticks(30);
            exp_q.push_back(mk(S_PLAY, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, s, 4'd0, 2'b00));
            ticks(60);
            cyc(2);
        end

        // 6: held collision gives one clash; collision in FREEZE gives none
        exp_q.push_back(mk(S_PLAY, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 4'd15, 4'd0, 2'b00));
        collision = 1'b1;
        cyc(5);
        collision = 1'b0;
        cyc(2);
        exp_q.push_back(mk(S_FRZ, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd15, 4'd1, 2'b00));
        dead_L = 1'b1;
        cyc(1);
        dead_L = 1'b0;
        collision = 1'b1;
        cyc(2);
        collision = 1'b0;
        ticks(3);

        // Reset in FREEZE returns everything to reset values on the next edge
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        compare("reset_in_freeze", act(), mk(S_IDLE, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 2'b00));
        cyc(1);
        reset = 1'b0;
        cyc(5);

        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d expected events never seen, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
